// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// width defaults, the halt opcode and both branch-target tables.
package fetch_pkg;

  localparam int PC_WIDTH_DEF    = 32'sd10;
  localparam int INSTR_WIDTH_DEF = 32'sd9;

  localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Absolute targets and signed relative offsets; truncated to PC width at use.
  localparam int LUT_ABS [4] = '{32'sd0, 32'sd16, 32'sd32, 32'sd63};
  localparam int LUT_REL [4] = '{32'sd2, -32'sd3, 32'sd16, -32'sd1};

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Branch-target table indexed by how_high. With FETCH_BRANCH_RELATIVE_EN the
// entries are signed PC offsets, otherwise absolute addresses.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic [1:0]          how_high,
  output logic [PC_WIDTH-1:0] entry
);

`ifdef FETCH_BRANCH_RELATIVE_EN
  localparam int LUT_SEL [4] = LUT_REL;
`else
  localparam int LUT_SEL [4] = LUT_ABS;
`endif

  // Table selection; negative offsets become two's complement at PC width.
  always_comb begin
    entry = '0;
    case (how_high)
      2'd0:    entry = PC_WIDTH'(LUT_SEL[0]);
      2'd1:    entry = PC_WIDTH'(LUT_SEL[1]);
      2'd2:    entry = PC_WIDTH'(LUT_SEL[2]);
      2'd3:    entry = PC_WIDTH'(LUT_SEL[3]);
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer with start/halt/done handshake.
// Optional build macro: FETCH_BRANCH_RELATIVE_EN (PC-relative branch targets).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                     PC_WIDTH    = PC_WIDTH_DEF,
  parameter int                     INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]    START_ADDR  = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(HALT_INSTR_DEF)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   branch,
  input  logic                   taken,
  input  logic [1:0]             how_high,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [PC_WIDTH-1:0]    prog_ctr,
  output logic                   running,
  output logic                   Done
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1'b1);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                done_q, done_d;
  logic [PC_WIDTH-1:0] lut_entry_s;
  logic [PC_WIDTH-1:0] target_s;
  logic                is_halt_s;

  branch_lut #(
    .PC_WIDTH (PC_WIDTH)
  ) u_lut (
    .how_high (how_high),
    .entry    (lut_entry_s)
  );

`ifdef FETCH_BRANCH_RELATIVE_EN
  assign target_s = pc_q + lut_entry_s;
`else
  assign target_s = lut_entry_s;
`endif

  assign is_halt_s = (instr_in == HALT_INSTR);

  // State, PC and Done registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= START_ADDR;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; Start only matters outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (is_halt_s) state_d = ST_HALT;
        else           state_d = ST_RUN;
      end
      ST_HALT: begin
        if (Start) state_d = ST_RUN;
        else       state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next-PC mux and Done update; branch/taken are only looked at in RUN.
  always_comb begin
    pc_d   = pc_q;
    done_d = done_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) pc_d = START_ADDR;
        else       pc_d = pc_q;
        done_d = 1'b0;
      end
      ST_RUN: begin
        if (is_halt_s) begin
          pc_d   = pc_q;
          done_d = 1'b1;
        end else if (branch && taken) begin
          pc_d   = target_s;
          done_d = 1'b0;
        end else begin
          pc_d   = pc_q + PC_ONE;
          done_d = 1'b0;
        end
      end
      ST_HALT: begin
        if (Start) begin
          pc_d   = START_ADDR;
          done_d = 1'b0;
        end else begin
          pc_d   = pc_q;
          done_d = 1'b1;
        end
      end
      default: begin
        pc_d   = START_ADDR;
        done_d = 1'b0;
      end
    endcase
  end

  assign prog_ctr = pc_q;
  assign running  = (state_q == ST_RUN);
  assign Done     = done_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic compared against a small behavioural model of the sequencer.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       branch;
  logic       taken;
  logic [1:0] how_high;
  logic [8:0] instr_in;
  logic [9:0] prog_ctr;
  logic       running;
  logic       Done;

  fetch_ctrl dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .branch   (branch),
    .taken    (taken),
    .how_high (how_high),
    .instr_in (instr_in),
    .prog_ctr (prog_ctr),
    .running  (running),
    .Done     (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: mode 0 = waiting for Start, 1 = executing, 2 = finished.
  int m_mode = 0;
  int m_pc   = 0;
  bit m_done = 1'b0;

  int tbl_abs [4] = '{0, 16, 32, 63};
  int tbl_rel [4] = '{2, -3, 16, -1};

  function automatic int branch_dest(input int pc, input int hh);
`ifdef FETCH_BRANCH_RELATIVE_EN
    return (pc + tbl_rel[hh] + 1024) % 1024;
`else
    return tbl_abs[hh];
`endif
  endfunction

  function automatic logic [11:0] model_out();
    return {10'(m_pc), (m_mode == 1), m_done};
  endfunction

  // Apply inputs, advance the model, clock once, return at the falling edge.
  task automatic tick(input bit rst, input bit st, input bit br, input bit tk,
                      input int hh, input int ins, input bit xq);
    Reset    = rst;
    Start    = st;
    branch   = br;
    taken    = tk;
    how_high = 2'(hh);
    instr_in = 9'(ins);
    if (xq && m_mode != 1) begin
      branch = 1'bx;
      taken  = 1'bx;
    end
    if (rst) begin
      m_mode = 0; m_pc = 0; m_done = 1'b0;
    end else if (m_mode == 1) begin
      if (ins == 'h1FF) begin
        m_mode = 2; m_done = 1'b1;
      end else if (br && tk) begin
        m_pc = branch_dest(m_pc, hh);
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end else if (st) begin
      m_mode = 1; m_pc = 0; m_done = 1'b0;
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic nop();
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go_to(input int target_pc);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1100 && m_pc != target_pc; i++) nop();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({prog_ctr, running, Done} !== {10'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold: got %h want %h", {prog_ctr, running, Done}, 12'h000);
      end
    end
    for (int i = 0; i < 5; i++) begin
      nop();
      n_cmp++;
      if ({prog_ctr, running, Done} !== {10'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_hold: got %h want %h", {prog_ctr, running, Done}, 12'h000);
      end
    end
  endtask

  task automatic test_sequential();
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nop();
      n_cmp++;
      if ({prog_ctr, running, Done} !== {10'(i), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL seq_pc: got %h want %h", {prog_ctr, running, Done}, {10'(i), 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_branch();
    logic [9:0] want;
    go_to(5);
    tick(0, 0, 1, 0, 2, 0, 0);
    n_cmp++;
    if ({prog_ctr, running} !== {10'd6, 1'b1}) begin
      n_fail++;
      $display("FAIL branch_not_taken: got %h want %h", prog_ctr, 10'd6);
    end
    go_to(5);
`ifdef FETCH_BRANCH_RELATIVE_EN
    tick(0, 0, 1, 1, 1, 0, 0);
    want = 10'd2;
`else
    tick(0, 0, 1, 1, 2, 0, 0);
    want = 10'h020;
`endif
    n_cmp++;
    if ({prog_ctr, running, Done} !== {want, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL branch_taken: got %h want %h", prog_ctr, want);
    end
  endtask

  task automatic test_halt();
    go_to(7);
    tick(0, 0, 1, 1, 2, 'h1FF, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nop();
      n_cmp++;
      if ({prog_ctr, running, Done} !== {10'd7, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL halt_hold: got %h want %h", {prog_ctr, running, Done}, {10'd7, 1'b0, 1'b1});
      end
    end
    tick(0, 1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({prog_ctr, running, Done} !== {10'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_restart: got %h want %h", {prog_ctr, running, Done}, {10'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_wrap();
    go_to(0);
    tick(0, 0, 1, 1, 3, 0, 0);
`ifdef FETCH_BRANCH_RELATIVE_EN
    n_cmp++;
    if (prog_ctr !== 10'h3FF) begin
      n_fail++;
      $display("FAIL wrap_neg_offset: got %h want %h", prog_ctr, 10'h3FF);
    end
`else
    for (int i = 0; i < 1100 && m_pc != 1023; i++) nop();
`endif
    n_cmp++;
    if ({prog_ctr, running} !== {10'h3FF, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_top: got %h want %h", prog_ctr, 10'h3FF);
    end
    nop();
    n_cmp++;
    if ({prog_ctr, running, Done} !== {10'h000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_zero: got %h want %h", prog_ctr, 10'h000);
    end
  endtask

  task automatic test_reset_midrun();
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      tick(0, 1, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({prog_ctr, running} !== {10'(i), 1'b1}) begin
        n_fail++;
        $display("FAIL start_in_run: got %h want %h", prog_ctr, 10'(i));
      end
    end
    tick(1, 0, 1, 1, 2, 0, 0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) nop();
      n_cmp++;
      if ({prog_ctr, running, Done} !== {10'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_midrun: got %h want %h", {prog_ctr, running, Done}, 12'h000);
      end
    end
  endtask

  task automatic test_random();
    int ins;
    tick(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) ins = 'h1FF;
      else ins = int'($urandom_range(0, 510));
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), ins, 1'($urandom));
      n_cmp++;
      if ({prog_ctr, running, Done} !== model_out()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, {prog_ctr, running, Done}, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter and fetch sequencer directly upstream of the control decoder.
- Drives the instruction ROM address each cycle. The ROM word goes to the decoder; the decoder's branch and how_high outputs come back here.
- Resolves taken branches through a small branch-target LUT indexed by how_high.
- Runs a start/halt/done handshake with the testbench or top level.

Parameters:
- PC_WIDTH, 10, width of program counter and instruction ROM address.
- INSTR_WIDTH, 9, width of the instruction word.
- START_ADDR, 0, PC value loaded on Start.
- HALT_INSTR, 9'h1FF, encoding that terminates execution.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; takes effect on the rising Clk edge.
- Start  in  1  request to begin execution; sampled in IDLE and HALT only.
- branch  in  1  from decoder; current instruction is a branch.
- taken  in  1  from ALU; branch condition true (zero/compare flag).
- how_high  in  2  from decoder; branch-target LUT index.
- instr_in  in  INSTR_WIDTH  ROM word at prog_ctr (combinational ROM).
- prog_ctr  out  PC_WIDTH  registered PC; ROM address.
- running  out  1  high while in RUN; enables RegWrite/MemWrite downstream.
- Done  out  1  registered; high from the cycle after HALT_INSTR is fetched until restart or Reset.

Behaviour:
- Reset (synchronous, active-high; highest priority) sets state IDLE, prog_ctr=START_ADDR, running=0, Done=0.
- States:
  - IDLE: prog_ctr holds. If Start=1, go to RUN and load prog_ctr=START_ADDR.
  - RUN: the instruction at prog_ctr executes this cycle. Next prog_ctr, in priority order:
    1. instr_in==HALT_INSTR: go to HALT, prog_ctr holds, Done<=1.
    2. branch&&taken: prog_ctr <= target (see below).
    3. Otherwise: prog_ctr <= prog_ctr+1.
    - Start is ignored in RUN.
  - HALT: prog_ctr holds, Done=1. If Start=1, go to RUN, prog_ctr<=START_ADDR, Done<=0.
- running is combinational from state==RUN, so it is high for exactly the cycles whose instruction executes.
- Latency: one instruction per cycle, no stalls, no delay slots. A taken branch redirects the very next fetch.
- Arithmetic: increment is modulo 2^PC_WIDTH; PC=all-ones increments to 0 with no error flag.
- Branch target: LUT entry selected by how_high; 4 entries, PC_WIDTH wide each.
- branch=1 with taken=0 falls through to prog_ctr+1.
- HALT_INSTR and a branch in the same cycle: halt wins.
- Unknown/X on branch or taken while not running is ignored.
- Reset mid-RUN: next cycle is IDLE with prog_ctr=START_ADDR. No partial state survives.

Optional Feature:
- Macro: FETCH_BRANCH_RELATIVE_EN.
- Defined: LUT entries are signed PC_WIDTH-bit offsets. Taken target = prog_ctr + offset, modulo 2^PC_WIDTH, so wrap-around in either direction is legal.
- Undefined: LUT entries are absolute addresses; target = LUT[how_high].
- The LUT contents differ between the two builds; both tables are defined in the package.

Decomposition:
- Package fetch_pkg holds:
  - state enum typedef (IDLE, RUN, HALT);
  - PC_WIDTH/INSTR_WIDTH defaults;
  - HALT_INSTR;
  - the two 4-entry LUT constant arrays (absolute: 0x000,0x010,0x020,0x03F; relative: +2, -3, +16, -1).
- One sub-module: branch_lut. Combinational; input how_high, output entry; selects the array by macro.
- fetch_ctrl holds the FSM, the PC register and the next-PC mux.

Test Plan:
- Reset held 2 cycles, then released with Start=0 -> prog_ctr=0, running=0, Done=0 held for 5 cycles.
- Start pulse, ROM of NOPs -> prog_ctr sequence 0,1,2,3 in consecutive cycles; running=1 from the cycle after Start.
- Taken branch:
  - Absolute build: at PC=5, branch=1, taken=1, how_high=2 -> next prog_ctr=0x020.
  - Relative build: same stimulus with how_high=1 -> next prog_ctr=2.
  - branch=1, taken=0 -> next prog_ctr=6.
- HALT_INSTR at PC=7 with branch=1, taken=1 -> prog_ctr stays 7, Done=1 next cycle, running=0. A Start 3 cycles later -> prog_ctr=0, Done=0.
- Wrap: prog_ctr=0x3FF, no branch -> next prog_ctr=0x000. Relative build: PC=0 with offset -1 -> 0x3FF.
- Reset asserted while running at PC=12 -> next cycle IDLE, prog_ctr=0, Done=0. Start pulsed during RUN has no effect.
